// File: rtl/pcoeff_result_accumulator.sv
// Collects per-bot summedData/pcoeffCount results from pipeline24Pack into one
// total per job and hands the total to the host via a valid/ready handshake.
module pcoeff_result_accumulator #(
    parameter int SUM_WIDTH         = 40,
    parameter int COUNT_WIDTH       = 5,
    parameter int TOTAL_SUM_WIDTH   = 64,
    parameter int TOTAL_COUNT_WIDTH = 40,
    parameter int JOB_WIDTH         = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         start_ready,
    input  logic [JOB_WIDTH-1:0]         job_bot_count,
    input  logic                         data_valid,
    input  logic [SUM_WIDTH-1:0]         summed_data,
    input  logic [COUNT_WIDTH-1:0]       pcoeff_count,
    output logic                         result_valid,
    input  logic                         result_ready,
    output logic [TOTAL_SUM_WIDTH-1:0]   total_sum,
    output logic [TOTAL_COUNT_WIDTH-1:0] total_count,
    output logic [JOB_WIDTH-1:0]         bots_received,
    output logic                         overflow,
    output logic                         stray_error
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                     state, nextState;
    logic [JOB_WIDTH-1:0]       expected;
    logic [TOTAL_SUM_WIDTH:0]   sumInc;
    logic [TOTAL_COUNT_WIDTH:0] countInc;
    logic [JOB_WIDTH-1:0]       botsInc;
    logic                       startAccept, absorb, lastBot, handshake;

    // One extra bit on each adder catches the carry that marks a wrapped total.
    assign sumInc   = {1'b0, total_sum}   + {1'b0, TOTAL_SUM_WIDTH'(summed_data)};
    assign countInc = {1'b0, total_count} + {1'b0, TOTAL_COUNT_WIDTH'(pcoeff_count)};
    assign botsInc  = bots_received + 1'b1;

    assign startAccept = (state == IDLE)  && start;
    assign absorb      = (state == ACCUM) && data_valid;
    assign lastBot     = absorb && (botsInc == expected);
    assign handshake   = (state == DONE)  && result_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (startAccept) nextState = (job_bot_count == '0) ? DONE : ACCUM;
            ACCUM:   if (lastBot)     nextState = DONE;
            DONE:    if (handshake)   nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        start_ready  = (state == IDLE);
        result_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expected      <= '0;
            total_sum     <= '0;
            total_count   <= '0;
            bots_received <= '0;
            overflow      <= 1'b0;
            stray_error   <= 1'b0;
        end else begin
            if (startAccept) begin
                expected      <= job_bot_count;
                total_sum     <= '0;
                total_count   <= '0;
                bots_received <= '0;
                overflow      <= 1'b0;
            end else if (absorb) begin
                total_sum     <= sumInc[TOTAL_SUM_WIDTH-1:0];
                total_count   <= countInc[TOTAL_COUNT_WIDTH-1:0];
                bots_received <= botsInc;
                overflow      <= overflow | sumInc[TOTAL_SUM_WIDTH] | countInc[TOTAL_COUNT_WIDTH];
            end
            // Results outside ACCUM (including alongside an accepted start) are dropped.
            if (data_valid && (state != ACCUM))
                stray_error <= 1'b1;
        end
    end

endmodule
